// File: rtl/imem_loader.sv
// imem_loader: receives a little-endian byte stream from a host, packs it into
// 32-bit instruction words and writes them to instruction memory. The core is
// held in reset until an all-zero terminator word has been written. If the
// memory fills up before a terminator arrives, the loader stops and flags overflow.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  // Index of the last word slot; a non-terminator written here means overflow.
  localparam logic [15:0] LAST_IDX = 16'(DEPTH - 1);

  state_t      state_reg;
  logic [1:0]  byte_cnt_reg;
  logic        accept;
  logic        restart;
  logic        word_complete;
  logic [31:0] full_word;

  assign in_ready      = (state_reg == LOAD);
  assign accept        = in_valid && in_ready;
  // start is only honoured outside LOAD, so a stray pulse cannot corrupt a session.
  assign restart       = start && (state_reg != LOAD);
  assign word_complete = accept && (byte_cnt_reg == 2'd3);

  // Lower three byte lanes of the word under assembly; the fourth byte is
  // taken straight from in_data so the word can be written the next cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_reg;

    // Capture the byte for this lane; cleared so a restart drops any partial word.
    always_ff @(posedge clk) begin
      if (rst || restart) begin
        lane_reg <= 8'h00;
      end else if (accept && (byte_cnt_reg == 2'(gi))) begin
        lane_reg <= in_data;
      end
    end
  end

  assign full_word = {in_data, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

  // Status outputs decode the state register only.
  assign core_hold = (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign overflow  = (state_reg == ERR);

  // Session FSM: byte counting, word write strobe, address/count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 2'd0;
      word_count   <= 16'd0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'h0000_0000;
    end else begin
      mem_we <= 1'b0;
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg    <= LOAD;
            byte_cnt_reg <= 2'd0;
            word_count   <= 16'd0;
          end
        end
        LOAD: begin
          if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
          end
          if (word_complete) begin
            mem_we     <= 1'b1;
            mem_wdata  <= full_word;
            mem_addr   <= BASE_ADDR + {14'd0, word_count, 2'b00};
            word_count <= word_count + 16'd1;
            // Terminator wins even when it lands in the last slot.
            if (full_word == 32'h0000_0000) begin
              state_reg <= DONE;
            end else if (word_count == LAST_IDX) begin
              state_reg <= ERR;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, is the instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first word written.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 in_data  input  8  program byte from the host stream.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  32  byte address of the word being written.
REQ-011 mem_wdata  output  32  instruction word being written.
REQ-012 core_hold  output  1  holds the core in reset while high.
REQ-013 done  output  1  program loaded; terminator word seen.
REQ-014 overflow  output  1  DEPTH words written with no terminator.
REQ-015 word_count  output  16  number of words written in the current session.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, DONE, ERR.
REQ-017 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 only in LOAD; it is combinational from state.
REQ-019 Bytes SHALL be assembled little-endian: the first byte goes to [7:0] and the fourth byte to [31:24].
REQ-020 A 2-bit byte counter SHALL advance once per accepted byte and wrap from 3 to 0.
REQ-021 On the cycle after the fourth byte is accepted, the block SHALL drive the following:
- mem_we=1 for exactly one cycle.
- mem_wdata = the assembled word.
- mem_addr = BASE_ADDR + 4*word_count, using the pre-increment word_count.
- word_count SHALL increment in the same cycle.
REQ-022 mem_addr and mem_wdata SHALL hold their last written values while mem_we=0.
REQ-023 Acceptance SHALL continue in the write cycle; no bubble is inserted in LOAD.
REQ-024 Terminator: if the assembled word is 32'h0000_0000, it SHALL be written as in REQ-021, and the FSM SHALL be in DONE in that same write cycle.
REQ-025 Overflow: if a non-zero word is written when word_count == DEPTH-1, the FSM SHALL go to ERR in that write cycle.
REQ-026 If the terminator is the DEPTH-th word, the terminator SHALL take priority and the FSM goes to DONE.
REQ-027 IDLE and start=1: the FSM SHALL enter LOAD next cycle, and clear word_count, the byte counter and the partial word.
REQ-028 start SHALL be ignored in LOAD.
REQ-029 In DONE or ERR, start=1 SHALL restart the load as in REQ-027.
REQ-030 Outputs by state:
- core_hold = 1 in IDLE, LOAD and ERR; 0 only in DONE.
- done = 1 only in DONE.
- overflow = 1 only in ERR.
REQ-031 A partial word (1-3 bytes) SHALL be discarded on restart or reset and is never written.
REQ-032 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-033 rst=1 SHALL force the following state on the next edge, regardless of current state:
- state = IDLE.
- mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0.
- word_count = 0, byte counter = 0.
- done = 0, overflow = 0, core_hold = 1, in_ready = 0.
REQ-034 rst SHALL take priority over start and over byte acceptance in the same cycle.
REQ-035 A reset mid-LOAD SHALL suppress any pending mem_we.

Verification
REQ-036 Basic load:
- Stimulus: start, then bytes 13 05 A0 00 | 00 00 00 00 with in_valid held high.
- Response: first write addr 0x0, data 0x00A00513; second write addr 0x4, data 0x00000000.
- Then done=1, core_hold=0, word_count=2.
REQ-037 Gaps in the stream:
- Stimulus: in_valid toggling 1/0 each cycle.
- Response: same data and addresses as REQ-036, each mem_we a single cycle.
REQ-038 Overflow with DEPTH=4:
- Stimulus: four non-zero words.
- Response: writes at 0x0, 0x4, 0x8, 0xC; then overflow=1, core_hold=1, in_ready=0.
REQ-039 Boundary with DEPTH=4:
- Stimulus: three non-zero words, then 00000000.
- Response: done=1, overflow=0, word_count=4.
REQ-040 Reset mid-word:
- Stimulus: rst asserted after 2 bytes of the second word.
- Response: no second write; IDLE with word_count=0.
- Then start plus one full program: writes start at BASE_ADDR.
REQ-041 Restart:
- Stimulus: start in DONE.
- Response: LOAD next cycle, core_hold=1, word_count=0, next write at BASE_ADDR.
